// File: rtl/sp_uram_arb.sv
// sp_uram_arb: round-robin write/read arbiter for one single-port URAM with read-latency tracking and a zero-fill FSM.
// Define SP_URAM_ARB_AUTO_INIT_EN to start the zero-fill automatically out of reset.
module sp_uram_arb #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 70,
    parameter int NBPIPE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout
);
    typedef enum logic {IDLE, INIT} state_t;
`ifdef SP_URAM_ARB_AUTO_INIT_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = IDLE;
`endif
    state_t            r_state, w_state_nx;
    logic [AWIDTH-1:0] r_cnt, w_cnt_nx;
    logic              r_rr_rd;
    logic [NBPIPE-1:0] r_vld;
    logic              r_done;
    logic              w_init, w_arb, w_wr_gnt, w_rd_gnt;
    logic [NBPIPE:0]   w_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == IDLE) begin
            if (init_start) begin
                w_state_nx = INIT;
                w_cnt_nx   = '0;
            end
        end else begin
            w_cnt_nx = r_cnt + 1'b1;
            if (&r_cnt)
                w_state_nx = IDLE;
        end
    end

    // r_rr_rd set means the read side wins the next contested cycle
    assign w_init   = r_state == INIT;
    assign w_arb    = r_state == IDLE && !init_start;
    assign w_wr_gnt = w_arb && wr_valid && (!rd_valid || !r_rr_rd);
    assign w_rd_gnt = w_arb && rd_valid && (!wr_valid || r_rr_rd);
    assign w_sh     = {r_vld, w_rd_gnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_rd <= 1'b1;
            r_vld   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_rr_rd <= w_wr_gnt ? 1'b1 : w_rd_gnt ? 1'b0 : r_rr_rd;
            r_vld   <= w_sh[NBPIPE-1:0];
            r_done  <= w_init && (&r_cnt);
        end
    end

    assign wr_ready  = w_wr_gnt;
    assign rd_ready  = w_rd_gnt;
    assign init_busy = w_init;
    assign init_done = r_done;
    assign mem_en    = w_init || w_wr_gnt || w_rd_gnt;
    assign mem_we    = w_init || w_wr_gnt;
    assign mem_addr  = w_init ? r_cnt : w_wr_gnt ? wr_addr : w_rd_gnt ? rd_addr : '0;
    assign mem_din   = w_wr_gnt ? wr_data : '0;
    assign rsp_valid = r_vld[NBPIPE-1];
    assign rsp_data  = rsp_valid ? mem_dout : '0;
endmodule

// File: tb/tb_sp_uram_arb.sv
// tb_sp_uram_arb: scoreboard bench for sp_uram_arb with a behavioural 2-stage URAM.
module tb_sp_uram_arb;
    localparam int AW = 4;
    localparam int DW = 70;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_start, init_busy, init_done;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, mem_addr;
    logic [DW-1:0] wr_data, rsp_data, mem_din, mem_dout;
    logic          rsp_valid, mem_en, mem_we;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [DW-1:0] q_data[$];
    int            q_cyc[$];

    logic [DW-1:0] m[16];
    logic [DW-1:0] s1, s2;

    sp_uram_arb #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(NP)) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) m[mem_addr] <= mem_din;
            else s1 <= m[mem_addr];
        end
        s2 <= s1;
    end
    assign mem_dout = s2;

    task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("both_ready", {69'd0, wr_ready & rd_ready}, 70'd0);
            if (rsp_valid) begin
                if (q_data.size() == 0) begin
                    chk("rsp_extra", {69'd0, rsp_valid}, 70'd0);
                end else begin
                    chk("rsp_data", rsp_data, q_data.pop_front());
                    chk("rsp_cycle", DW'(cyc), DW'(q_cyc.pop_front()));
                end
            end else begin
                chk("rsp_data_idle", rsp_data, '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [DW-1:0] d);
        q_data.push_back(d);
        q_cyc.push_back(cyc + NP);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        chk("wr_ready", {69'd0, wr_ready}, 70'd1);
        chk("wr_mem_addr", DW'(mem_addr), DW'(a));
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_valid = 1'b1; rd_addr = a;
        @(negedge clk);
        chk("rd_ready", {69'd0, rd_ready}, 70'd1);
        chk("rd_mem_we", {69'd0, mem_we}, 70'd0);
        expect_rsp(e);
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_data.delete();
        q_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; init_start = 0; wr_valid = 0; rd_valid = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
`ifdef SP_URAM_ARB_AUTO_INIT_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("auto_busy", {69'd0, init_busy}, 70'd1);
            chk("auto_addr", DW'(mem_addr), DW'(i));
            chk("auto_done_low", {69'd0, init_done}, 70'd0);
            tick();
        end
        @(negedge clk);
        chk("auto_busy_end", {69'd0, init_busy}, 70'd0);
        chk("auto_done", {69'd0, init_done}, 70'd1);
        tick();
        wr(4'd3, 70'h2A);
        rd(4'd3, 70'h2A);
        repeat (4) tick();
`else
        @(negedge clk);
        chk("rst_busy", {69'd0, init_busy}, 70'd0);
        chk("rst_done", {69'd0, init_done}, 70'd0);
        chk("rst_rsp_valid", {69'd0, rsp_valid}, 70'd0);
        chk("rst_mem_en", {69'd0, mem_en}, 70'd0);
        tick();
        wr(4'd3, 70'h2A);
        rd(4'd3, 70'h2A);
        repeat (4) tick();

        do_reset();
        wr_valid = 1; wr_addr = 4'd5; wr_data = 70'h55;
        rd_valid = 1; rd_addr = 4'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_rd_ready", {69'd0, rd_ready}, {69'd0, k % 2 == 0});
            chk("alt_wr_ready", {69'd0, wr_ready}, {69'd0, k % 2 == 1});
            if (k % 2 == 0) expect_rsp(70'h2A);
            tick();
        end
        wr_valid = 0; rd_valid = 0;
        repeat (4) tick();

        for (int i = 0; i < 16; i++) wr(AW'(i), 70'hA000 + 70'(i));
        rd(4'd7, 70'hA007);
        init_start = 1; wr_valid = 1; rd_valid = 1; rd_addr = 4'd9;
        @(negedge clk);
        chk("start_wr_ready", {69'd0, wr_ready}, 70'd0);
        chk("start_rd_ready", {69'd0, rd_ready}, 70'd0);
        chk("start_busy", {69'd0, init_busy}, 70'd0);
        tick();
        init_start = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_busy", {69'd0, init_busy}, 70'd1);
            chk("init_wr_ready", {69'd0, wr_ready}, 70'd0);
            chk("init_rd_ready", {69'd0, rd_ready}, 70'd0);
            chk("init_addr", DW'(mem_addr), DW'(i));
            chk("init_we", {69'd0, mem_we}, 70'd1);
            chk("init_din", mem_din, '0);
            chk("init_done_low", {69'd0, init_done}, 70'd0);
            tick();
        end
        wr_valid = 0; rd_addr = 4'd0;
        @(negedge clk);
        chk("end_busy", {69'd0, init_busy}, 70'd0);
        chk("end_done", {69'd0, init_done}, 70'd1);
        chk("end_rd_ready", {69'd0, rd_ready}, 70'd1);
        expect_rsp('0);
        tick();
        rd_valid = 0;
        @(negedge clk);
        chk("done_pulse_width", {69'd0, init_done}, 70'd0);
        tick();
        for (int i = 1; i < 16; i++) rd(AW'(i), '0);
        repeat (4) tick();

        init_start = 1;
        tick();
        init_start = 0;
        repeat (7) tick();
        chk("rst_mid_addr", DW'(mem_addr), 70'd7);
        rst = 1'b1;
        q_data.delete();
        q_cyc.delete();
        #1;
        chk("rst_mid_busy", {69'd0, init_busy}, 70'd0);
        chk("rst_mid_rsp", {69'd0, rsp_valid}, 70'd0);
        chk("rst_mid_mem_en", {69'd0, mem_en}, 70'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", {69'd0, init_done}, 70'd0);
            chk("rst_mid_idle", {69'd0, init_busy}, 70'd0);
        end
`endif
        chk("rsp_outstanding", DW'(q_data.size()), 70'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sp_uram_arb.md
Name: sp_uram_arb

Overview:
- Two-requester arbiter and sequencer for one single-port URAM instance (sp_uram) in the reduce buffer.
- Shares the one port between a write requester and a read requester with round-robin priority.
- Tracks read latency so returned data carries a valid strobe.
- Contains a clear FSM that zero-fills the whole memory on request.

Parameters:
- AWIDTH, 12, URAM address width; depth is 2^AWIDTH.
- DWIDTH, 70, data width.
- NBPIPE, 1, URAM output pipeline depth. Read latency equals NBPIPE, and NBPIPE must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- init_start  in  1  one-cycle pulse; starts the zero-fill
- init_busy  out  1  high while the zero-fill runs
- init_done  out  1  one-cycle pulse when the zero-fill completes
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  AWIDTH  write address
- wr_data  in  DWIDTH  write data
- rd_valid  in  1  read request
- rd_ready  out  1  read accepted this cycle
- rd_addr  in  AWIDTH  read address
- rsp_valid  out  1  read data valid
- rsp_data  out  DWIDTH  read data
- mem_en  out  1  to URAM mem_en
- mem_we  out  1  to URAM we
- mem_addr  out  AWIDTH  to URAM addr
- mem_din  out  DWIDTH  to URAM din
- mem_dout  in  DWIDTH  from URAM dout

Behaviour:
- Reset values:
  - state IDLE, init counter 0, rr_ptr = read-priority.
  - Read-valid shift register all 0.
  - init_busy, init_done, rsp_valid all 0.
- Handshake:
  - A transfer happens on a cycle with valid && ready.
  - wr_ready and rd_ready are combinational from state, both valids, rr_ptr and init_start.
  - At most one of wr_ready and rd_ready is high in any cycle.
- Arbitration in IDLE when init_start=0:
  - Only one valid: that requester is granted.
  - Both valid: the requester named by rr_ptr is granted.
  - rr_ptr then points at the other requester; it is unchanged on cycles with no grant.
- URAM drive (combinational):
  - Granted write: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_din=wr_data.
  - Granted read: mem_en=1, mem_we=0, mem_addr=rd_addr, mem_din=0.
  - Idle: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- Read latency:
  - A granted read in cycle t sets the shift register input.
  - rsp_valid=1 in cycle t+NBPIPE with rsp_data=mem_dout.
  - rsp_data=0 whenever rsp_valid=0. Responses have no backpressure.
  - Back-to-back reads give back-to-back responses in order.
- Hazard: a write in cycle t followed by a read of the same address in t+1 or later returns the new data. No forwarding is needed.
- FSM states IDLE, INIT:
  - IDLE -> INIT when init_start=1. Both readies are forced 0 in that cycle, and init counter is cleared to 0.
  - In INIT: mem_en=1, mem_we=1, mem_addr=counter, mem_din=0, counter increments each cycle.
  - In INIT: init_busy=1, both readies 0, init_start ignored.
  - INIT -> IDLE after the cycle writing address 2^AWIDTH-1; the counter wraps to 0.
  - init_done pulses 1 in the first IDLE cycle after INIT.
  - Grants resume in that same cycle.
- Reads in flight when INIT begins still complete on schedule, with rsp_valid as above.
- Reset mid-INIT:
  - Returns to IDLE (or re-enters INIT per the optional feature).
  - The shift register clears, so pending responses are dropped.
  - init_done does not pulse.

Optional Feature:
- Macro SP_URAM_ARB_AUTO_INIT_EN.
- Defined: the reset state is INIT with counter 0, so the zero-fill starts automatically on the first clk edge after rst deasserts. init_done pulses on completion as usual.
- Undefined: the reset state is IDLE and the zero-fill runs only on init_start.

Test Plan:
- Test AWIDTH=4, NBPIPE=2.
- Write addr 3 data 0x2A, then read addr 3 next cycle -> rsp_valid exactly 2 cycles after rd grant, rsp_data=0x2A.
- wr_valid and rd_valid held high for 4 cycles after reset -> grants alternate rd, wr, rd, wr; never both ready in one cycle.
- Fill addrs 0..15 with nonzero data, pulse init_start -> init_busy high for exactly 16 cycles, readies 0 throughout, init_done single pulse. Reading all 16 addrs then returns 0.
- Read granted one cycle before init_start -> its response arrives on time during INIT with correct data.
- Assert rst at INIT counter=7 -> init_busy=0, rsp_valid=0 immediately, no init_done pulse.
- With SP_URAM_ARB_AUTO_INIT_EN: release reset -> init_busy=1 for 16 cycles, then init_done pulse, without any init_start.
